// File: rtl/mux_nch_rr_if.sv
// Handshake/bus bundle for mux_nch_rr: channel inputs, requests and the
// registered valid/ready output side. master = producer/consumer side, slave = selector.
interface mux_nch_rr_if #(
  parameter int unsigned N_CH  = 8,
  parameter int unsigned WIDTH = 2,
  parameter int unsigned SEL_W = 3
);
  logic                    mode;
  logic [SEL_W-1:0]        sel;
  logic [N_CH*WIDTH-1:0]   data_in;
  logic [N_CH-1:0]         req;
  logic                    out_ready;
  logic [WIDTH-1:0]        data_out;
  logic [SEL_W-1:0]        ch_out;
  logic                    out_valid;
  logic [N_CH-1:0]         grant;
  logic                    timeout;

  modport master (
    output mode, sel, data_in, req, out_ready,
    input  data_out, ch_out, out_valid, grant, timeout
  );

  modport slave (
    input  mode, sel, data_in, req, out_ready,
    output data_out, ch_out, out_valid, grant, timeout
  );
endinterface

// File: rtl/mux_nch_rr.sv
// Registered N-channel selector (manual / round-robin) with valid/ready output.
// Optional hold timeout enabled by defining MUX_HOLD_TIMEOUT_EN.
module mux_nch_rr #(
  parameter int unsigned N_CH        = 8,
  parameter int unsigned WIDTH       = 2,
  parameter int unsigned SEL_W       = 3,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic         clk,
  input  logic         rst,
  mux_nch_rr_if.slave  bus
);

  localparam int unsigned SEL_REQ = ($clog2(N_CH) < 1) ? 1 : $clog2(N_CH);

  if (SEL_W != SEL_REQ) begin : g_bad_sel_w
    $error("mux_nch_rr: SEL_W must equal max(1, clog2(N_CH))");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
    $error("mux_nch_rr: TIMEOUT_CYC out of range 1..65535");
  end
  if (N_CH < 2 || N_CH > 32) begin : g_bad_nch
    $error("mux_nch_rr: N_CH out of range 2..32");
  end

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_data;
  logic [SEL_W-1:0] r_ch;
  logic [SEL_W-1:0] r_ptr;
  logic [N_CH-1:0]  r_grant;
  logic             r_timeout;

  logic             w_arb_en;
  logic             w_hold;
  logic             w_drop;
  logic             w_capture;
  logic             w_elig;
  logic [SEL_W-1:0] w_win;
  logic [SEL_W-1:0] w_ptr_nxt;
  logic [WIDTH-1:0] w_word;
  logic [N_CH-1:0]  w_onehot;

  logic             w_man_hit;
  logic [SEL_W-1:0] w_man_win;
  logic [N_CH-1:0]  w_rot;
  logic             w_rr_found;
  logic [SEL_W-1:0] w_rr_off;
  logic [SEL_W:0]   w_rr_sum;
  logic [SEL_W-1:0] w_rr_win;

  assign w_arb_en = (r_state == S_EMPTY) || bus.out_ready;
  assign w_hold   = (r_state == S_FULL) && !bus.out_ready;

  // Manual select: an out-of-range sel simply never matches any channel.
  always_comb begin
    w_man_hit = 1'b0;
    w_man_win = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (32'(bus.sel) == k && bus.req[k]) begin
        w_man_hit = 1'b1;
        w_man_win = SEL_W'(k);
      end
    end
  end

  // Round-robin: rotate requests so the pointer lands on bit 0, take the
  // lowest set bit, then add the pointer back modulo N_CH.
  assign w_rot = N_CH'({bus.req, bus.req} >> r_ptr);

  always_comb begin
    w_rr_found = 1'b0;
    w_rr_off   = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (!w_rr_found && w_rot[i]) begin
        w_rr_found = 1'b1;
        w_rr_off   = SEL_W'(i);
      end
    end
    w_rr_sum = {1'b0, r_ptr} + {1'b0, w_rr_off};
    if (32'(w_rr_sum) >= N_CH) begin
      w_rr_sum = w_rr_sum - (SEL_W+1)'(N_CH);
    end
    w_rr_win = w_rr_sum[SEL_W-1:0];
  end

  assign w_elig    = bus.mode ? w_rr_found : w_man_hit;
  assign w_win     = bus.mode ? w_rr_win   : w_man_win;
  assign w_capture = w_arb_en && w_elig;
  assign w_onehot  = {{(N_CH-1){1'b0}}, 1'b1} << w_win;
  assign w_ptr_nxt = (32'(w_win) == N_CH - 1) ? '0 : w_win + SEL_W'(1);

  always_comb begin
    w_word = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (32'(w_win) == k) begin
        w_word = bus.data_in[k*WIDTH +: WIDTH];
      end
    end
  end

`ifdef MUX_HOLD_TIMEOUT_EN
  logic [15:0] r_tcnt;

  // Drop on the hold cycle that brings the count to TIMEOUT_CYC.
  assign w_drop = w_hold && (r_tcnt == 16'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tcnt <= '0;
    end else if (w_hold && !w_drop) begin
      r_tcnt <= r_tcnt + 16'd1;
    end else begin
      r_tcnt <= '0;
    end
  end
`else
  assign w_drop = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: begin
        if (w_capture) w_state_nxt = S_FULL;
      end
      S_FULL: begin
        if (bus.out_ready) begin
          w_state_nxt = w_capture ? S_FULL : S_EMPTY;
        end else if (w_drop) begin
          w_state_nxt = S_EMPTY;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data    <= '0;
      r_ch      <= '0;
      r_ptr     <= '0;
      r_grant   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_grant   <= w_capture ? w_onehot : '0;
      r_timeout <= w_drop;
      if (w_capture) begin
        r_data <= w_word;
        r_ch   <= w_win;
        if (bus.mode) r_ptr <= w_ptr_nxt;
      end
    end
  end

  // Output logic
  always_comb begin
    bus.out_valid = (r_state == S_FULL);
    bus.data_out  = r_data;
    bus.ch_out    = r_ch;
    bus.grant     = r_grant;
    bus.timeout   = r_timeout;
  end

endmodule
